// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the add/sub issue controller:
//   - operation encoding (OP_ADD / OP_SUB)
//   - FSM state enum (IDLE, WAIT, RESP)
//   - request core struct {op, a, b}. The tag is appended in the top module
//     because its width is a module parameter.
//   - calc_flag(): carry / negative flag from the popped operands.
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
    } req_core_t;

    // The datapath cout is unusable, so the flag is rebuilt here in 5-bit
    // arithmetic: bit 4 of the sum for add, a<b (negative) for subtract.
    function automatic logic calc_flag(input logic op, input logic [3:0] a,
                                       input logic [3:0] b);
        logic [4:0] sum_s;
        logic       flag_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (op == OP_SUB) begin
            flag_s = (a < b);
        end else begin
            flag_s = sum_s[4];
        end
        return flag_s;
    endfunction

endpackage

// File: rtl/addsub_req_fifo.sv
// -----------------------------------------------------------------------------
// addsub_req_fifo
// DEPTH-entry synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty can be told apart. Both flags are registered, so a push into an empty
// FIFO is poppable from the next cycle only, and a pop never frees a slot for
// a push in the same cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request (ignored when full)
//   pop          read request (ignored when empty)
//   rdata        head entry, valid while !empty
//   full, empty  registered status flags
// -----------------------------------------------------------------------------
module addsub_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [W-1:0]  mem_r [DEPTH];
    logic          full_r;
    logic          empty_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push && !full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next pointer values after this cycle's push/pop
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointers and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            full_r   <= (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
            empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
        end
    end

    // Storage array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/addsub_issue_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_issue_ctrl
// Front-end for the 4-bit combinational add/sub datapath. Requests are queued
// in addsub_req_fifo and issued one at a time. Each operation holds its
// operands on dp_m/dp_a/dp_b for DP_WAIT cycles, samples dp_s and returns it
// with a locally computed carry/negative flag on a valid/ready response port.
// Optional feature macro: ADDSUB_STATS_EN adds the stat_ops/stat_neg counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake (ready = FIFO not full)
//   req_op/req_a/req_b/req_tag       request payload (op: 0 add, 1 sub)
//   dp_m/dp_a/dp_b                   registered datapath drive
//   dp_s/dp_cout                     datapath result (dp_cout is ignored)
//   rsp_valid/rsp_ready              response handshake
//   rsp_s/rsp_flag/rsp_tag           response payload
//   busy                             operation in progress or requests queued
//   stat_ops/stat_neg                (ADDSUB_STATS_EN only) saturating counters
// -----------------------------------------------------------------------------
module addsub_issue_ctrl
    import addsub_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DP_WAIT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dp_m,
    output logic [3:0]       dp_a,
    output logic [3:0]       dp_b,
    input  logic [3:0]       dp_s,
    input  logic             dp_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_s,
    output logic             rsp_flag,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
`ifdef ADDSUB_STATS_EN
    ,
    output logic [7:0]       stat_ops,
    output logic [7:0]       stat_neg
`endif
);

    if (DP_WAIT < 1) begin : g_bad_dp_wait
        $error("addsub_issue_ctrl: DP_WAIT must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("addsub_issue_ctrl: DEPTH must be a power of 2, >= 2");
    end

    typedef struct packed {
        req_core_t        core;
        logic [TAG_W-1:0] tag;
    } req_entry_t;

    localparam int                CW       = (DP_WAIT > 1) ? $clog2(DP_WAIT) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'(DP_WAIT - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    req_entry_t       wr_entry_s;
    req_entry_t       head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic             capture_s;
    logic             retire_s;
    logic [CW-1:0]    cnt_r;
    logic             dp_m_r;
    logic [3:0]       dp_a_r;
    logic [3:0]       dp_b_r;
    logic             flag_r;
    logic [TAG_W-1:0] tag_r;
    logic             rsp_valid_r;
    logic [3:0]       rsp_s_r;
    logic             rsp_flag_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic             unused_cout_s;

    assign unused_cout_s   = dp_cout;
    assign wr_entry_s.core = '{op: req_op, a: req_a, b: req_b};
    assign wr_entry_s.tag  = req_tag;

    addsub_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(req_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .wdata (wr_entry_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign req_ready = !fifo_full_s;
    assign dp_m      = dp_m_r;
    assign dp_a      = dp_a_r;
    assign dp_b      = dp_b_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_s     = rsp_s_r;
    assign rsp_flag  = rsp_flag_r;
    assign rsp_tag   = rsp_tag_r;
    assign busy      = (state_r != IDLE) || !fifo_empty_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and issue/capture/retire strobes. On a response accept the
    // next request is popped in the same cycle, so there is no IDLE bubble.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        retire_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    capture_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    retire_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand issue: datapath drive, settle counter, flag and tag of the op
    // in flight. dp_* keep the last operands once the op completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_m_r <= 1'b0;
            dp_a_r <= 4'd0;
            dp_b_r <= 4'd0;
            flag_r <= 1'b0;
            tag_r  <= {TAG_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else if (pop_s) begin
            dp_m_r <= head_s.core.op;
            dp_a_r <= head_s.core.a;
            dp_b_r <= head_s.core.b;
            flag_r <= calc_flag(head_s.core.op, head_s.core.a, head_s.core.b);
            tag_r  <= head_s.tag;
            cnt_r  <= CNT_LOAD;
        end else if ((state_r == WAIT) && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // Response registers: loaded once per op, held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_s_r     <= 4'd0;
            rsp_flag_r  <= 1'b0;
            rsp_tag_r   <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            rsp_valid_r <= 1'b1;
            rsp_s_r     <= dp_s;
            rsp_flag_r  <= flag_r;
            rsp_tag_r   <= tag_r;
        end else if (retire_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

`ifdef ADDSUB_STATS_EN
    logic [7:0] stat_ops_r;
    logic [7:0] stat_neg_r;

    assign stat_ops = stat_ops_r;
    assign stat_neg = stat_neg_r;

    // Saturating counters of accepted responses and negative sub results.
    // dp_m_r still holds the retiring op's mode at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_r <= 8'd0;
            stat_neg_r <= 8'd0;
        end else if (retire_s) begin
            if (stat_ops_r != 8'hFF) begin
                stat_ops_r <= stat_ops_r + 8'd1;
            end
            if ((dp_m_r == OP_SUB) && rsp_flag_r && (stat_neg_r != 8'hFF)) begin
                stat_neg_r <= stat_neg_r + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
module tb_addsub_issue_ctrl;

    localparam int TAG_W = 4;

    typedef struct {
        logic             op;
        logic [3:0]       a;
        logic [3:0]       b;
        logic [TAG_W-1:0] tag;
        logic [3:0]       s;
        logic             f;
    } vec_t;

    typedef struct {
        logic [3:0]       s;
        logic             f;
        logic [TAG_W-1:0] tag;
        logic             op;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main DUT (DP_WAIT=1)
    logic             req_valid, req_ready, req_op;
    logic [3:0]       req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             dp_m, dp_cout;
    logic [3:0]       dp_a, dp_b, dp_s;
    logic             rsp_valid, rsp_ready, rsp_flag, busy;
    logic [3:0]       rsp_s;
    logic [TAG_W-1:0] rsp_tag;
`ifdef ADDSUB_STATS_EN
    logic [7:0]       stat_ops, stat_neg;
    logic [7:0]       d3_stat_ops, d3_stat_neg;
`endif

    // Streaming DUT (DP_WAIT=3)
    logic             d3_req_valid, d3_req_ready, d3_req_op;
    logic [3:0]       d3_req_a, d3_req_b;
    logic [TAG_W-1:0] d3_req_tag;
    logic             d3_dp_m, d3_dp_cout;
    logic [3:0]       d3_dp_a, d3_dp_b, d3_dp_s;
    logic             d3_rsp_valid, d3_rsp_ready, d3_rsp_flag, d3_busy;
    logic [3:0]       d3_rsp_s;
    logic [TAG_W-1:0] d3_rsp_tag;

    // Combinational add/sub datapath model
    function automatic logic [3:0] dp_model(input logic m, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        if (m) r = (a > b) ? a - b : b - a;
        else   r = a + b;
        return r;
    endfunction

    assign dp_s       = dp_model(dp_m, dp_a, dp_b);
    assign dp_cout    = dp_a[0] ^ dp_b[3];
    assign d3_dp_s    = dp_model(d3_dp_m, d3_dp_a, d3_dp_b);
    assign d3_dp_cout = d3_dp_a[3];

    addsub_issue_ctrl #(.DEPTH(4), .DP_WAIT(1), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .dp_m(dp_m), .dp_a(dp_a), .dp_b(dp_b), .dp_s(dp_s), .dp_cout(dp_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
        .rsp_flag(rsp_flag), .rsp_tag(rsp_tag), .busy(busy)
`ifdef ADDSUB_STATS_EN
        , .stat_ops(stat_ops), .stat_neg(stat_neg)
`endif
    );

    addsub_issue_ctrl #(.DEPTH(4), .DP_WAIT(3), .TAG_W(TAG_W)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_op(d3_req_op),
        .req_a(d3_req_a), .req_b(d3_req_b), .req_tag(d3_req_tag),
        .dp_m(d3_dp_m), .dp_a(d3_dp_a), .dp_b(d3_dp_b), .dp_s(d3_dp_s), .dp_cout(d3_dp_cout),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_s(d3_rsp_s),
        .rsp_flag(d3_rsp_flag), .rsp_tag(d3_rsp_tag), .busy(d3_busy)
`ifdef ADDSUB_STATS_EN
        , .stat_ops(d3_stat_ops), .stat_neg(d3_stat_neg)
`endif
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc1 = 0, acc3 = 0;
    int   rsp1_cnt = 0, rsp3_cnt = 0;
    int   last3 = 0;
    int   ops_model = 0, neg_model = 0;
    exp_t q1[$];
    exp_t q3[$];
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: expected response from the arithmetic rules
    function automatic exp_t mk_exp(input logic op, input logic [3:0] a, input logic [3:0] b,
                                    input logic [TAG_W-1:0] tag);
        exp_t e;
        int   r;
        if (op) begin
            r   = int'(a) - int'(b);
            e.s = 4'((r < 0) ? -r : r);
            e.f = (r < 0);
        end else begin
            r   = int'(a) + int'(b);
            e.s = 4'(r % 16);
            e.f = (r > 15);
        end
        e.tag = tag;
        e.op  = op;
        return e;
    endfunction

    // One clock: scoreboard both ports at the negedge, return 1 after posedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                rsp1_cnt++;
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: got tag %0d, want no response", rsp_tag);
                end else begin
                    e = q1.pop_front();
                    chk("rsp_s", rsp_s, e.s);
                    chk("rsp_flag", rsp_flag, e.f);
                    chk("rsp_tag", rsp_tag, e.tag);
                    if (ops_model < 255) ops_model++;
                    if (e.op && e.f && neg_model < 255) neg_model++;
                end
            end
            if (req_valid && req_ready) begin
                q1.push_back(mk_exp(req_op, req_a, req_b, req_tag));
                acc1++;
            end
            if (d3_rsp_valid && d3_rsp_ready) begin
                if (q3.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d3_rsp_unexpected: got tag %0d, want no response", d3_rsp_tag);
                end else begin
                    e = q3.pop_front();
                    chk("d3_rsp_s", d3_rsp_s, e.s);
                    chk("d3_rsp_flag", d3_rsp_flag, e.f);
                    chk("d3_rsp_tag", d3_rsp_tag, e.tag);
                end
                if (rsp3_cnt > 0) chk("stream_gap", cyc - last3, 4);
                last3 = cyc;
                rsp3_cnt++;
            end
            if (d3_req_valid && d3_req_ready) begin
                q3.push_back(mk_exp(d3_req_op, d3_req_a, d3_req_b, d3_req_tag));
                acc3++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_one(input logic op, input logic [3:0] a, input logic [3:0] b,
                            input logic [TAG_W-1:0] tag);
        int a0 = acc1;
        int g  = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        while (acc1 == a0 && g < 50) begin
            tick();
            g++;
        end
        req_valid = 1'b0;
        chk("push_accept", acc1 - a0, 1);
    endtask

    task automatic drain1(input string name);
        int g = 0;
        rsp_ready = 1'b1;
        while ((q1.size() != 0 || rsp_valid) && g < 300) begin
            tick();
            g++;
        end
        chk(name, q1.size(), 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 1);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_dp"}, {dp_m, dp_a, dp_b}, 0);
        chk({pfx, "_rsp"}, {rsp_s, rsp_flag, rsp_tag}, 0);
    endtask

    task automatic clear_model();
        q1.delete(); q3.delete();
        ops_model = 0; neg_model = 0;
    endtask

    initial begin
        int lat;
        int c0;
        int g;
        logic [TAG_W-1:0] tagc;

        vt[0] = '{1'b0, 4'd9,  4'd8,  4'd3,  4'd1,  1'b1};
        vt[1] = '{1'b1, 4'd3,  4'd5,  4'd4,  4'd2,  1'b1};
        vt[2] = '{1'b1, 4'd5,  4'd3,  4'd5,  4'd2,  1'b0};
        vt[3] = '{1'b1, 4'd7,  4'd7,  4'd6,  4'd0,  1'b0};
        vt[4] = '{1'b0, 4'd15, 4'd15, 4'd7,  4'd14, 1'b1};
        vt[5] = '{1'b0, 4'd0,  4'd0,  4'd8,  4'd0,  1'b0};
        vt[6] = '{1'b0, 4'd8,  4'd7,  4'd9,  4'd15, 1'b0};
        vt[7] = '{1'b1, 4'd0,  4'd15, 4'd10, 4'd15, 1'b1};
        vt[8] = '{1'b1, 4'd15, 4'd0,  4'd11, 4'd15, 1'b0};
        vt[9] = '{1'b0, 4'd1,  4'd15, 4'd12, 4'd0,  1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 1'b0; req_a = 4'd0; req_b = 4'd0; req_tag = '0;
        rsp_ready = 1'b0;
        d3_req_valid = 1'b0; d3_req_op = 1'b0; d3_req_a = 4'd0; d3_req_b = 4'd0; d3_req_tag = '0;
        d3_rsp_ready = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed vectors, one op at a time, rsp_ready high
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; req_op = vt[i].op; req_a = vt[i].a; req_b = vt[i].b; req_tag = vt[i].tag;
            tick();
            req_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("tbl_latency", lat, 2);
            chk("tbl_s", rsp_s, vt[i].s);
            chk("tbl_flag", rsp_flag, vt[i].f);
            chk("tbl_tag", rsp_tag, vt[i].tag);
            tick();
            chk("tbl_rsp_clear", rsp_valid, 0);
            chk("tbl_dp_hold", {dp_m, dp_a, dp_b}, {vt[i].op, vt[i].a, vt[i].b});
        end

        // Backpressure: 5 requests, 1 in flight + 4 buffered
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 1'($urandom_range(1));
            req_a = 4'($urandom_range(15)); req_b = 4'($urandom_range(15)); req_tag = 4'(i + 1);
            tick();
        end
        chk("bp_full", req_ready, 0);
        req_op = 1'b0; req_a = 4'd1; req_b = 4'd1; req_tag = 4'd6;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_tag", rsp_tag, q1[0].tag);
            chk("bp_hold_s", {rsp_s, rsp_flag}, {q1[0].s, q1[0].f});
            tick();
        end
        req_valid = 1'b0;
        c0 = rsp1_cnt;
        drain1("bp_drain");
        chk("bp_count", rsp1_cnt - c0, 5);
        repeat (5) tick();

        // Streaming on DP_WAIT=3: one response every 4 cycles
        d3_rsp_ready = 1'b1;
        g = 0;
        while (acc3 < 6 && g < 100) begin
            d3_req_valid = 1'b1; d3_req_op = 1'($urandom_range(1));
            d3_req_a = 4'($urandom_range(15)); d3_req_b = 4'($urandom_range(15));
            d3_req_tag = 4'(acc3 + 1);
            tick();
            g++;
        end
        d3_req_valid = 1'b0;
        g = 0;
        while ((q3.size() != 0 || d3_rsp_valid) && g < 100) begin
            tick();
            g++;
        end
        chk("stream_count", rsp3_cnt, 6);

        // Reset during WAIT with two requests queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_op = 1'b0; req_a = 4'(i); req_b = 4'd2; req_tag = 4'(8 + i);
            tick();
        end
        req_valid = 1'b0;
        g = 0;
        while (!rsp_valid && g < 20) begin
            tick();
            g++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_in_wait", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        clear_model();
        tick(); tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        c0 = rsp1_cnt;
        repeat (10) tick();
        chk("rst_mid_no_rsp", rsp1_cnt - c0, 0);
        chk("rst_mid_idle", busy, 0);

        // Random traffic against the reference queue
        tagc = '0;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(9) < 6);
            req_op = 1'($urandom_range(1));
            req_a = 4'($urandom_range(15)); req_b = 4'($urandom_range(15));
            req_tag = tagc;
            tagc = tagc + 4'd1;
            rsp_ready = ($urandom_range(3) != 0);
            tick();
        end
        req_valid = 1'b0;
        drain1("rand_drain");
`ifdef ADDSUB_STATS_EN
        chk("rand_stat_ops", stat_ops, ops_model);
        chk("rand_stat_neg", stat_neg, neg_model);

        // Statistics counters and saturation
        rst_n = 1'b0;
        clear_model();
        tick(); tick();
        chk("stat_rst_ops", stat_ops, 0);
        chk("stat_rst_neg", stat_neg, 0);
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        push_one(1'b1, 4'd1, 4'd2, 4'd1);
        push_one(1'b1, 4'd0, 4'd9, 4'd2);
        push_one(1'b1, 4'd4, 4'd15, 4'd3);
        push_one(1'b0, 4'd3, 4'd4, 4'd4);
        push_one(1'b0, 4'd9, 4'd9, 4'd5);
        drain1("stat5_drain");
        chk("stat5_ops", stat_ops, 5);
        chk("stat5_neg", stat_neg, 3);
        for (int i = 0; i < 300; i++) begin
            push_one(1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)), 4'(i));
        end
        drain1("stat_sat_drain");
        chk("stat_sat_ops", stat_ops, 255);
        chk("stat_sat_neg", stat_neg, neg_model);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
